// File: rtl/booth_mac_sequencer.sv
// Radix-4 Booth multiply(-accumulate) sequencer driving a shared partial-product generator.
// Optional running-sum accumulator enabled by defining BOOTH_MAC_ACCUM_EN.
module booth_mac_sequencer #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    input  logic             acc_clr,
    output logic [2:0]       pp_action,
    output logic [7:0]       pp_multiplicand,
    input  logic [8:0]       pp_partial,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       digit_r;
    logic [7:0]       mcand_r;
    logic [7:0]       mplier_r;
    logic [15:0]      product_r;
    logic [2:0]       action_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [ACC_W-1:0] result_r;

    logic             accept_s;
    logic             run_last_s;
    logic [2:0]       shamt_s;
    logic [15:0]      pp_ext_s;
    logic [15:0]      neg_ext_s;
    logic [15:0]      product_next_s;
    logic [ACC_W-1:0] done_value_s;

    // Triplet {b[2i+1], b[2i], b[2i-1]} with b[-1] = 0.
    function automatic logic [2:0] booth_triplet(input logic [7:0] b, input logic [1:0] idx);
        logic [8:0] bx;
        bx = {b, 1'b0};
        return bx[{idx, 1'b0} +: 3];
    endfunction

    function automatic logic [2:0] booth_encode(input logic [2:0] trip);
        logic [2:0] act;
        case (trip)
            3'b000, 3'b111: act = 3'b000;
            3'b001, 3'b010: act = 3'b001;
            3'b011:         act = 3'b010;
            3'b100:         act = 3'b110;
            3'b101, 3'b110: act = 3'b101;
            default:        act = 3'b000;
        endcase
        return act;
    endfunction

    assign accept_s   = (state_r == ST_IDLE) && in_valid && in_ready_r;
    assign run_last_s = (state_r == ST_RUN) && (digit_r == 2'd3);
    assign shamt_s    = {digit_r, 1'b0};
    assign pp_ext_s   = {{7{pp_partial[8]}}, pp_partial};
    // The +1 completes the two's complement of a one's-complemented partial.
    assign neg_ext_s  = {15'd0, action_r[2]};
    assign product_next_s = product_r + (pp_ext_s << shamt_s) + (neg_ext_s << shamt_s);

`ifdef BOOTH_MAC_ACCUM_EN
    logic             clr_r;
    logic [ACC_W-1:0] acc_r;

    // Accumulator folds in the finished product as the sequencer enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_r <= 1'b0;
            acc_r <= {ACC_W{1'b0}};
        end else begin
            if (accept_s) begin
                clr_r <= acc_clr;
            end
            if (run_last_s) begin
                acc_r <= (clr_r ? {ACC_W{1'b0}} : acc_r) + ACC_W'($signed(product_next_s));
            end
        end
    end

    assign done_value_s = acc_r;
`else
    logic acc_clr_unused_s;

    assign acc_clr_unused_s = acc_clr;
    assign done_value_s     = ACC_W'($signed(product_r));
`endif

    // Sequencer FSM, digit stepping, product register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            digit_r     <= 2'd0;
            mcand_r     <= 8'd0;
            mplier_r    <= 8'd0;
            product_r   <= 16'd0;
            action_r    <= 3'b000;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_RUN;
                        mcand_r    <= op_a;
                        mplier_r   <= op_b;
                        product_r  <= 16'd0;
                        digit_r    <= 2'd0;
                        action_r   <= booth_encode(booth_triplet(op_b, 2'd0));
                        in_ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    product_r <= product_next_s;
                    digit_r   <= digit_r + 2'd1;
                    if (run_last_s) begin
                        state_r  <= ST_DONE;
                        action_r <= 3'b000;
                    end else begin
                        action_r <= booth_encode(booth_triplet(mplier_r, digit_r + 2'd1));
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        result_r    <= done_value_s;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    action_r    <= 3'b000;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_r;
    assign out_valid       = out_valid_r;
    assign pp_action       = action_r;
    assign pp_multiplicand = mcand_r;
    assign result          = result_r;

endmodule
